// File: rtl/cpu2core_timer_pkg.sv
// Shared definitions for the cpu2core interval timer: register map, control
// bit positions and the driver FSM state encoding.
package cpu2core_timer_pkg;

    localparam logic [2:0] TMR_STATUS   = 3'd0;
    localparam logic [2:0] TMR_CONTROL  = 3'd1;
    localparam logic [2:0] TMR_PERIOD_L = 3'd2;
    localparam logic [2:0] TMR_PERIOD_H = 3'd3;
    localparam logic [2:0] TMR_SNAP_L   = 3'd4;
    localparam logic [2:0] TMR_SNAP_H   = 3'd5;

    localparam int unsigned CTRL_ITO   = 0;
    localparam int unsigned CTRL_CONT  = 1;
    localparam int unsigned CTRL_START = 2;
    localparam int unsigned CTRL_STOP  = 3;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_CFG_PL   = 4'd1,
        ST_CFG_PH   = 4'd2,
        ST_CFG_CTRL = 4'd3,
        ST_RUN      = 4'd4,
        ST_ACK      = 4'd5,
        ST_SNAP     = 4'd6,
        ST_RD_L     = 4'd7,
        ST_RD_H     = 4'd8,
        ST_RD_D     = 4'd9,
        ST_STOP     = 4'd10
    } state_e;

    function automatic logic [15:0] ctrl_word(input logic ito, input logic cont,
                                              input logic start, input logic stop);
        logic [15:0] w;
        w              = '0;
        w[CTRL_ITO]    = ito;
        w[CTRL_CONT]   = cont;
        w[CTRL_START]  = start;
        w[CTRL_STOP]   = stop;
        return w;
    endfunction

endpackage

// File: rtl/cpu2core_timer0_driver.sv
// Avalon-MM master that programs the cpu2core interval timer and services its
// interrupts autonomously, publishing a tick count and counter snapshot.
module cpu2core_timer0_driver
    import cpu2core_timer_pkg::*;
#(
    parameter longint unsigned PERIOD_CYCLES = 64'd50000,
    parameter bit              CONTINUOUS    = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        stop,
    input  logic        irq,
    input  logic [15:0] readdata,
    output logic [2:0]  address,
    output logic        chipselect,
    output logic        write_n,
    output logic [15:0] writedata,
    output logic [31:0] tick_count,
    output logic        tick_pulse,
    output logic [31:0] snapshot,
    output logic        busy
);

    localparam logic [31:0] PERIOD_M1 = 32'(PERIOD_CYCLES - 64'd1);
    localparam logic [15:0] CTRL_GO   = ctrl_word(1'b1, CONTINUOUS, 1'b1, 1'b0);
    localparam logic [15:0] CTRL_HALT = ctrl_word(1'b0, 1'b0, 1'b0, 1'b1);

    state_e      state_q, state_d;
    logic        stop_pend_q, stop_pend_d;
    logic [15:0] snap_lo_q, snap_lo_d;
    logic [31:0] snapshot_q, snapshot_d;
    logic [31:0] tick_count_q, tick_count_d;
    logic        tick_pulse_q, tick_pulse_d;
    logic        busy_q, busy_d;
    logic [2:0]  address_q, address_d;
    logic        cs_q, cs_d;
    logic        write_n_q, write_n_d;
    logic [15:0] writedata_q, writedata_d;

    // NOTE: every always_comb output gets a default first, so no path leaves a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (start) state_d = ST_CFG_PL;
            ST_CFG_PL:   state_d = ST_CFG_PH;
            ST_CFG_PH:   state_d = ST_CFG_CTRL;
            ST_CFG_CTRL: state_d = ST_RUN;
            ST_RUN: begin
                if (stop_pend_q || stop) state_d = ST_STOP;
                else if (irq)            state_d = ST_ACK;
            end
            ST_ACK:      state_d = ST_SNAP;
            ST_SNAP:     state_d = ST_RD_L;
            ST_RD_L:     state_d = ST_RD_H;
            ST_RD_H:     state_d = ST_RD_D;
            ST_RD_D:     state_d = ST_RUN;
            ST_STOP:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // A stop requested mid-sequence is held until RUN so the sequence completes.
    always_comb begin
        stop_pend_d = stop_pend_q;
        if (state_q == ST_RUN) begin
            stop_pend_d = 1'b0;
        end else if (stop && (state_q != ST_IDLE || start)) begin
            stop_pend_d = 1'b1;
        end
    end

    always_comb begin
        snap_lo_d    = snap_lo_q;
        snapshot_d   = snapshot_q;
        tick_count_d = tick_count_q;
        tick_pulse_d = 1'b0;
        if (state_q == ST_RD_H) begin
            snap_lo_d = readdata;
        end
        if (state_q == ST_RD_D) begin
            snapshot_d   = {readdata, snap_lo_q};
            tick_count_d = tick_count_q + 32'd1;
            tick_pulse_d = 1'b1;
        end
        busy_d = (state_d != ST_IDLE);
    end

    // Bus outputs are decoded from the next state and registered, so they line up with state_q.
    always_comb begin
        address_d   = '0;
        cs_d        = 1'b0;
        write_n_d   = 1'b1;
        writedata_d = '0;
        unique case (state_d)
            ST_CFG_PL: begin
                cs_d = 1'b1; write_n_d = 1'b0; address_d = TMR_PERIOD_L; writedata_d = PERIOD_M1[15:0];
            end
            ST_CFG_PH: begin
                cs_d = 1'b1; write_n_d = 1'b0; address_d = TMR_PERIOD_H; writedata_d = PERIOD_M1[31:16];
            end
            ST_CFG_CTRL: begin
                cs_d = 1'b1; write_n_d = 1'b0; address_d = TMR_CONTROL; writedata_d = CTRL_GO;
            end
            ST_ACK: begin
                cs_d = 1'b1; write_n_d = 1'b0; address_d = TMR_STATUS;
            end
            ST_SNAP: begin
                cs_d = 1'b1; write_n_d = 1'b0; address_d = TMR_SNAP_L;
            end
            ST_RD_L: begin
                cs_d = 1'b1; address_d = TMR_SNAP_L;
            end
            ST_RD_H: begin
                cs_d = 1'b1; address_d = TMR_SNAP_H;
            end
            ST_STOP: begin
                cs_d = 1'b1; write_n_d = 1'b0; address_d = TMR_CONTROL; writedata_d = CTRL_HALT;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            stop_pend_q  <= 1'b0;
            snap_lo_q    <= '0;
            snapshot_q   <= '0;
            tick_count_q <= '0;
            tick_pulse_q <= 1'b0;
            busy_q       <= 1'b0;
            address_q    <= '0;
            cs_q         <= 1'b0;
            write_n_q    <= 1'b1;
            writedata_q  <= '0;
        end else begin
            state_q      <= state_d;
            stop_pend_q  <= stop_pend_d;
            snap_lo_q    <= snap_lo_d;
            snapshot_q   <= snapshot_d;
            tick_count_q <= tick_count_d;
            tick_pulse_q <= tick_pulse_d;
            busy_q       <= busy_d;
            address_q    <= address_d;
            cs_q         <= cs_d;
            write_n_q    <= write_n_d;
            writedata_q  <= writedata_d;
        end
    end

    assign address    = address_q;
    assign chipselect = cs_q;
    assign write_n    = write_n_q;
    assign writedata  = writedata_q;
    assign tick_count = tick_count_q;
    assign tick_pulse = tick_pulse_q;
    assign snapshot   = snapshot_q;
    assign busy       = busy_q;

endmodule
